// File: rtl/adc_acq_wingen_multi.sv
// Multi-echo ADC acquisition window generator: on each ACQ_WND rising edge, waits D cycles
// and then emits N gates of S cycles each, separated by G idle cycles, with echo index and status.
module adc_acq_wingen_multi #(
  parameter int SAMPLES_PER_ECHO_WIDTH = 32,
  parameter int ADC_INIT_DELAY_WIDTH   = 32,
  parameter int ECHO_CNT_WIDTH         = 16,
  parameter int ECHO_SPACING_WIDTH     = 32
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic [ADC_INIT_DELAY_WIDTH-1:0]   ADC_INIT_DELAY,
  input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
  input  logic [ECHO_CNT_WIDTH-1:0]         ECHOES_PER_SCAN,
  input  logic [ECHO_SPACING_WIDTH-1:0]     ECHO_SPACING,
  input  logic                              ACQ_WND,
  output logic                              ACQ_EN,
  output logic                              ECHO_START,
  output logic [ECHO_CNT_WIDTH-1:0]         ECHO_IDX,
  output logic                              BUSY,
  output logic                              DONE,
  output logic                              ABORT
);

  localparam logic [SAMPLES_PER_ECHO_WIDTH-1:0] S_ONE = 1;
  localparam logic [ADC_INIT_DELAY_WIDTH-1:0]   D_ONE = 1;
  localparam logic [ECHO_CNT_WIDTH-1:0]         N_ONE = 1;
  localparam logic [ECHO_SPACING_WIDTH-1:0]     G_ONE = 1;

  typedef enum logic [2:0] {IDLE, DELAY, ACQ, GAP, HOLD} state_t;

  state_t                            state_q, state_d;
  logic                              wnd_q;
  logic                              trig;
  logic [ADC_INIT_DELAY_WIDTH-1:0]   dly_q, dly_d;
  logic [SAMPLES_PER_ECHO_WIDTH-1:0] smp_q, smp_d, s_q, s_d;
  logic [ECHO_CNT_WIDTH-1:0]         n_q, n_d, idx_q, idx_d;
  logic [ECHO_SPACING_WIDTH-1:0]     gap_q, gap_d, g_q, g_d;
  logic                              acq_q, acq_d, start_q, start_d, abort_q, abort_d;

  assign trig = ACQ_WND & ~wnd_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    smp_d   = smp_q;
    gap_d   = gap_q;
    s_d     = s_q;
    n_d     = n_q;
    g_d     = g_q;
    idx_d   = idx_q;
    acq_d   = acq_q;
    start_d = 1'b0;
    abort_d = 1'b0;
    case (state_q)
      IDLE: begin
        acq_d = 1'b0;
        if (trig) begin
          s_d   = SAMPLES_PER_ECHO;
          n_d   = ECHOES_PER_SCAN;
          g_d   = ECHO_SPACING;
          dly_d = ADC_INIT_DELAY;
          idx_d = '0;
          if (SAMPLES_PER_ECHO == '0 || ECHOES_PER_SCAN == '0) state_d = HOLD;
          else state_d = DELAY;
        end
      end
      DELAY: begin
        if (!wnd_q) begin
          state_d = IDLE;
          acq_d   = 1'b0;
          abort_d = 1'b1;
        end else if (dly_q == '0) begin
          state_d = ACQ;
          acq_d   = 1'b1;
          start_d = 1'b1;
          smp_d   = s_q - S_ONE;
        end else begin
          dly_d = dly_q - D_ONE;
        end
      end
      ACQ: begin
        // An abort in the last sample cycle takes priority over completion.
        if (!wnd_q) begin
          state_d = IDLE;
          acq_d   = 1'b0;
          abort_d = 1'b1;
        end else if (smp_q == '0) begin
          if (idx_q == n_q - N_ONE) begin
            state_d = HOLD;
            acq_d   = 1'b0;
          end else begin
            idx_d = idx_q + N_ONE;
            if (g_q == '0) begin
              smp_d   = s_q - S_ONE;
              start_d = 1'b1;
            end else begin
              state_d = GAP;
              acq_d   = 1'b0;
              gap_d   = g_q - G_ONE;
            end
          end
        end else begin
          smp_d = smp_q - S_ONE;
        end
      end
      GAP: begin
        if (!wnd_q) begin
          state_d = IDLE;
          acq_d   = 1'b0;
          abort_d = 1'b1;
        end else if (gap_q == '0) begin
          state_d = ACQ;
          acq_d   = 1'b1;
          start_d = 1'b1;
          smp_d   = s_q - S_ONE;
        end else begin
          gap_d = gap_q - G_ONE;
        end
      end
      HOLD: begin
        acq_d = 1'b0;
        if (!wnd_q) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        acq_d   = 1'b0;
      end
    endcase
  end

  // wnd_q resets high so a window already open at reset release is not a trigger.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      wnd_q   <= 1'b1;
      dly_q   <= '0;
      smp_q   <= '0;
      gap_q   <= '0;
      s_q     <= '0;
      n_q     <= '0;
      g_q     <= '0;
      idx_q   <= '0;
      acq_q   <= 1'b0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wnd_q   <= ACQ_WND;
      dly_q   <= dly_d;
      smp_q   <= smp_d;
      gap_q   <= gap_d;
      s_q     <= s_d;
      n_q     <= n_d;
      g_q     <= g_d;
      idx_q   <= idx_d;
      acq_q   <= acq_d;
      start_q <= start_d;
      abort_q <= abort_d;
    end
  end

  assign ACQ_EN     = acq_q;
  assign ECHO_START = start_q;
  assign ECHO_IDX   = idx_q;
  assign ABORT      = abort_q;
  assign DONE       = (state_q == HOLD);
  assign BUSY       = (state_q == DELAY) || (state_q == ACQ) || (state_q == GAP);

endmodule

// File: tb/tb_adc_acq_wingen_multi.sv
// Directed testbench for adc_acq_wingen_multi; time t counts edges after the trigger edge k.
module tb_adc_acq_wingen_multi;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] ADC_INIT_DELAY;
  logic [31:0] SAMPLES_PER_ECHO;
  logic [15:0] ECHOES_PER_SCAN;
  logic [31:0] ECHO_SPACING;
  logic        ACQ_WND;
  logic        ACQ_EN;
  logic        ECHO_START;
  logic [15:0] ECHO_IDX;
  logic        BUSY;
  logic        DONE;
  logic        ABORT;

  int nAssert = 0;
  int nFail   = 0;

  adc_acq_wingen_multi dut (
    .CLK(CLK), .RESET(RESET), .ADC_INIT_DELAY(ADC_INIT_DELAY),
    .SAMPLES_PER_ECHO(SAMPLES_PER_ECHO), .ECHOES_PER_SCAN(ECHOES_PER_SCAN),
    .ECHO_SPACING(ECHO_SPACING), .ACQ_WND(ACQ_WND), .ACQ_EN(ACQ_EN),
    .ECHO_START(ECHO_START), .ECHO_IDX(ECHO_IDX), .BUSY(BUSY), .DONE(DONE), .ABORT(ABORT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setParams(input int d, input int s, input int n, input int g);
    ADC_INIT_DELAY   = d;
    SAMPLES_PER_ECHO = s;
    ECHOES_PER_SCAN  = n[15:0];
    ECHO_SPACING     = g;
  endtask

  // Closes the window and lets the DUT return to IDLE.
  task automatic closeWindow();
    ACQ_WND = 1'b0;
    repeat (3) step();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ACQ_WND = 1'b0;
    setParams(2, 10, 3, 4);
    repeat (3) step();
    nAssert++;
    if ({ACQ_EN, ECHO_START, BUSY, DONE, ABORT} !== 5'b0 || ECHO_IDX !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL reset_outputs got en/st/busy/done/abort=%b idx=%0d exp 00000 idx=0",
               {ACQ_EN, ECHO_START, BUSY, DONE, ABORT}, ECHO_IDX);
    end
    RESET = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_basic_scan();
    logic expAcq, expStart, expDone, expBusy;
    logic [15:0] expIdx;
    setParams(2, 10, 3, 4);
    ACQ_WND = 1'b1;
    for (int t = 0; t <= 46; t++) begin
      step();
      expAcq   = (t >= 3 && t < 13) || (t >= 17 && t < 27) || (t >= 31 && t < 41);
      expStart = (t == 3) || (t == 17) || (t == 31);
      expIdx   = (t < 13) ? 16'd0 : (t < 27) ? 16'd1 : 16'd2;
      expDone  = (t >= 41);
      expBusy  = (t < 41);
      nAssert++;
      if (ACQ_EN !== expAcq || ECHO_START !== expStart || DONE !== expDone ||
          BUSY !== expBusy || ECHO_IDX !== expIdx || ABORT !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL basic_scan t=%0d got en=%b st=%b done=%b busy=%b idx=%0d abort=%b exp en=%b st=%b done=%b busy=%b idx=%0d abort=0",
                 t, ACQ_EN, ECHO_START, DONE, BUSY, ECHO_IDX, ABORT,
                 expAcq, expStart, expDone, expBusy, expIdx);
      end
    end
    ACQ_WND = 1'b0;
    step();
    nAssert++;
    if (DONE !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL done_hold_one_edge got %b exp 1", DONE);
    end
    step();
    nAssert++;
    if (DONE !== 1'b0 || ECHO_IDX !== 16'd2) begin
      nFail++;
      $display("[TB] FAIL done_clear got done=%b idx=%0d exp done=0 idx=2", DONE, ECHO_IDX);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic expAcq, expStart, expDone;
    logic [15:0] expIdx;
    setParams(0, 5, 4, 0);
    ACQ_WND = 1'b1;
    for (int t = 0; t <= 24; t++) begin
      step();
      expAcq   = (t >= 1 && t < 21);
      expStart = (t == 1) || (t == 6) || (t == 11) || (t == 16);
      expIdx   = (t < 6) ? 16'd0 : (t < 11) ? 16'd1 : (t < 16) ? 16'd2 : 16'd3;
      expDone  = (t >= 21);
      nAssert++;
      if (ACQ_EN !== expAcq || ECHO_START !== expStart || DONE !== expDone || ECHO_IDX !== expIdx) begin
        nFail++;
        $display("[TB] FAIL back_to_back t=%0d got en=%b st=%b done=%b idx=%0d exp en=%b st=%b done=%b idx=%0d",
                 t, ACQ_EN, ECHO_START, DONE, ECHO_IDX, expAcq, expStart, expDone, expIdx);
      end
    end
    closeWindow();
  endtask

  task automatic test_abort();
    int enCnt, stCnt;
    setParams(2, 10, 3, 4);
    ACQ_WND = 1'b1;
    for (int t = 0; t <= 20; t++) step();
    ACQ_WND = 1'b0;
    step();
    nAssert++;
    if (ACQ_EN !== 1'b1 || ABORT !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_latency got en=%b abort=%b exp en=1 abort=0", ACQ_EN, ABORT);
    end
    step();
    nAssert++;
    if (ACQ_EN !== 1'b0 || ABORT !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_pulse got en=%b abort=%b done=%b busy=%b exp 0 1 0 0",
               ACQ_EN, ABORT, DONE, BUSY);
    end
    step();
    nAssert++;
    if (ABORT !== 1'b0 || DONE !== 1'b0) begin
      nFail++;
      $display("[TB] FAIL abort_one_cycle got abort=%b done=%b exp 0 0", ABORT, DONE);
    end
    ACQ_WND = 1'b1;
    enCnt = 0;
    stCnt = 0;
    for (int t = 0; t <= 42; t++) begin
      step();
      if (ACQ_EN) enCnt++;
      if (ECHO_START) stCnt++;
    end
    nAssert++;
    if (enCnt != 30 || stCnt != 3 || DONE !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL rescan_after_abort got en_cycles=%0d starts=%0d done=%b exp 30 3 1",
               enCnt, stCnt, DONE);
    end
    closeWindow();
  endtask

  task automatic test_zero_len();
    bit bad;
    for (int cfg = 0; cfg < 3; cfg++) begin
      if (cfg < 2) setParams(2, 0, 3, 4);
      else setParams(2, 10, 0, 4);
      ACQ_WND = 1'b1;
      step();
      nAssert++;
      if (DONE !== 1'b1 || BUSY !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL zero_done_edge cfg=%0d got done=%b busy=%b exp 1 0", cfg, DONE, BUSY);
      end
      bad = 1'b0;
      for (int t = 0; t < 12; t++) begin
        step();
        if (ACQ_EN !== 1'b0 || DONE !== 1'b1) bad = 1'b1;
      end
      nAssert++;
      if (bad) begin
        nFail++;
        $display("[TB] FAIL zero_hold cfg=%0d got en=%b done=%b exp en=0 done=1 throughout", cfg, ACQ_EN, DONE);
      end
      ACQ_WND = 1'b0;
      repeat (2) step();
      nAssert++;
      if (DONE !== 1'b0) begin
        nFail++;
        $display("[TB] FAIL zero_done_clear cfg=%0d got %b exp 0", cfg, DONE);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_scan();
    bit bad;
    setParams(2, 10, 3, 4);
    ACQ_WND = 1'b1;
    for (int t = 0; t <= 20; t++) step();
    RESET = 1'b1;
    step();
    nAssert++;
    if ({ACQ_EN, ECHO_START, BUSY, DONE, ABORT} !== 5'b0 || ECHO_IDX !== 16'd0) begin
      nFail++;
      $display("[TB] FAIL reset_mid_scan got en/st/busy/done/abort=%b idx=%0d exp 00000 idx=0",
               {ACQ_EN, ECHO_START, BUSY, DONE, ABORT}, ECHO_IDX);
    end
    RESET = 1'b0;
    bad = 1'b0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (ACQ_EN !== 1'b0 || BUSY !== 1'b0) bad = 1'b1;
    end
    nAssert++;
    if (bad) begin
      nFail++;
      $display("[TB] FAIL no_retrigger_after_reset got en=%b busy=%b exp 0 0 throughout", ACQ_EN, BUSY);
    end
    ACQ_WND = 1'b0;
    repeat (2) step();
    ACQ_WND = 1'b1;
    for (int t = 0; t <= 3; t++) begin
      step();
      nAssert++;
      if (ACQ_EN !== (t == 3) || BUSY !== 1'b1) begin
        nFail++;
        $display("[TB] FAIL retrigger_after_reset t=%0d got en=%b busy=%b exp en=%b busy=1",
                 t, ACQ_EN, BUSY, (t == 3));
      end
    end
    closeWindow();
  endtask

  task automatic test_param_change();
    int enCnt;
    setParams(2, 10, 3, 4);
    ACQ_WND = 1'b1;
    step();
    SAMPLES_PER_ECHO = 3;
    enCnt = 0;
    for (int t = 1; t <= 42; t++) begin
      step();
      if (ACQ_EN) enCnt++;
    end
    nAssert++;
    if (enCnt != 30 || DONE !== 1'b1) begin
      nFail++;
      $display("[TB] FAIL shadow_params got en_cycles=%0d done=%b exp 30 1", enCnt, DONE);
    end
    closeWindow();
    ACQ_WND = 1'b1;
    enCnt = 0;
    for (int t = 0; t <= 21; t++) begin
      step();
      if (ACQ_EN) enCnt++;
      if (t == 19 || t == 20) begin
        nAssert++;
        if (DONE !== (t == 20)) begin
          nFail++;
          $display("[TB] FAIL new_params_done t=%0d got %b exp %b", t, DONE, (t == 20));
        end
      end
    end
    nAssert++;
    if (enCnt != 9) begin
      nFail++;
      $display("[TB] FAIL new_params_len got en_cycles=%0d exp 9", enCnt);
    end
    closeWindow();
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_back_to_back();
    test_abort();
    test_zero_len();
    test_reset_mid_scan();
    test_param_change();
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
